cut_emulator: RTL and testbench

//  Parametrised, synthesisable chip-under-test emulator for tester self-test. It sits on
//  the dut_if mosi/miso pins in place of a real CUT and produces deterministic responses.

---
 rtl/cut_emulator.sv | 134 +++++++++++++
 tb/tb_cut_emulator.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cut_emulator.sv
// Chip-under-test emulator: a per-mode transform feeds a LATENCY-deep pipeline, and the
// pipeline output can be overridden by a stuck-at fault mask.
module cut_emulator #(
  parameter int              WIDTH   = 24,
  parameter int              LATENCY = 1,
  parameter logic [WIDTH-1:0] POLY   = 24'hE10000,
  parameter logic [WIDTH-1:0] SEED   = 24'h000001,
  localparam int             SW      = $clog2(WIDTH),
  localparam int             FW      = $clog2(LATENCY + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [SW-1:0]    shamt,
  input  logic             fault_en,
  input  logic [WIDTH-1:0] fault_mask,
  input  logic [WIDTH-1:0] fault_val,
  input  logic [WIDTH-1:0] mosi_data,
  output logic [WIDTH-1:0] miso_data,
  output logic             miso_valid
);

  typedef enum logic [2:0] {
    M_PASS = 3'd0, M_SHL = 3'd1, M_ROL = 3'd2, M_INV = 3'd3,
    M_ACC  = 3'd4, M_CNT = 3'd5, M_LFSR = 3'd6, M_XPV = 3'd7
  } mode_e;

  mode_e            mode_q, mode_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [WIDTH-1:0] acc_q, acc_d, cnt_q, cnt_d, lfsr_q, lfsr_d, prev_q, prev_d;
  logic [WIDTH-1:0] pipe_q [LATENCY];
  logic [WIDTH-1:0] pipe_d [LATENCY];

  logic                 chg_s;
  logic [WIDTH-1:0]     acc_e_s, cnt_e_s, lfsr_e_s, prev_e_s, f_s;
  logic [2*WIDTH-1:0]   rot_s;
  logic [SW-1:0]        rot_amt_s;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] x);
    lfsr_step = x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
  endfunction

  // Next-state: stage-0 function, mode-change restart, fill counter and pipeline shift.
  always_comb begin
    mode_d    = mode_q;
    fill_d    = fill_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    prev_d    = prev_q;
    pipe_d    = pipe_q;
    f_s       = {WIDTH{1'b0}};
    rot_amt_s = SW'(int'(shamt) % WIDTH);
    rot_s     = {mosi_data, mosi_data} << rot_amt_s;
    chg_s     = enable && (mode != mode_q);
    // A mode change restarts the mode state and the restarted value feeds this cycle's f.
    acc_e_s   = chg_s ? {WIDTH{1'b0}} : acc_q;
    cnt_e_s   = chg_s ? {WIDTH{1'b0}} : cnt_q;
    prev_e_s  = chg_s ? {WIDTH{1'b0}} : prev_q;
    lfsr_e_s  = (chg_s || (lfsr_q == {WIDTH{1'b0}})) ? SEED : lfsr_q;
    if (enable) begin
      mode_d = mode_e'(mode);
      if (chg_s) begin
        fill_d = FW'(1);
      end else if (fill_q == FW'(LATENCY)) begin
        fill_d = fill_q;
      end else begin
        fill_d = fill_q + FW'(1);
      end
      acc_d  = acc_e_s;
      cnt_d  = cnt_e_s;
      lfsr_d = lfsr_e_s;
      prev_d = prev_e_s;
      case (mode_e'(mode))
        M_PASS: f_s = mosi_data;
        M_SHL:  f_s = (int'(shamt) >= WIDTH) ? {WIDTH{1'b0}} : (mosi_data << shamt);
        M_ROL:  f_s = rot_s[2*WIDTH-1:WIDTH];
        M_INV:  f_s = ~mosi_data;
        M_ACC: begin
          acc_d = acc_e_s + mosi_data;
          f_s   = acc_d;
        end
        M_CNT: begin
          f_s   = cnt_e_s;
          cnt_d = cnt_e_s + {{(WIDTH-1){1'b0}}, 1'b1};
        end
        M_LFSR: begin
          f_s    = lfsr_e_s;
          lfsr_d = lfsr_step(lfsr_e_s);
        end
        M_XPV: begin
          f_s    = mosi_data ^ prev_e_s;
          prev_d = mosi_data;
        end
        default: f_s = mosi_data;
      endcase
      pipe_d[0] = f_s;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end else begin
      pipe_d = pipe_q;
    end
  end

  // State registers with synchronous reset that overrides enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q <= M_PASS;
      fill_q <= {FW{1'b0}};
      acc_q  <= {WIDTH{1'b0}};
      cnt_q  <= {WIDTH{1'b0}};
      lfsr_q <= SEED;
      prev_q <= {WIDTH{1'b0}};
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      mode_q <= mode_d;
      fill_q <= fill_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      lfsr_q <= lfsr_d;
      prev_q <= prev_d;
      pipe_q <= pipe_d;
    end
  end

  assign miso_data  = fault_en ? ((pipe_q[LATENCY-1] & ~fault_mask) | (fault_val & fault_mask))
                               : pipe_q[LATENCY-1];
  assign miso_valid = (fill_q == FW'(LATENCY));

endmodule

// File: tb/tb_cut_emulator.sv
// Bench for cut_emulator: directed literal checks plus randomized traffic compared every
// cycle against a queue-based reference model.
module tb_cut_emulator;
  localparam int          W   = 24;
  localparam int          L   = 2;
  localparam logic [23:0] PLY = 24'hE10000;
  localparam logic [23:0] SD  = 24'h000001;

  logic        clock = 1'b0;
  logic        reset, enable, fault_en;
  logic [2:0]  mode;
  logic [4:0]  shamt;
  logic [23:0] fault_mask, fault_val, mosi_data, miso_data;
  logic        miso_valid;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // model state
  logic [23:0] q [$];
  logic [23:0] m_acc, m_cnt, m_lfsr, m_prev;
  logic [2:0]  m_mode;
  int          since;

  cut_emulator #(.WIDTH(W), .LATENCY(L), .POLY(PLY), .SEED(SD)) dut (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode), .shamt(shamt),
    .fault_en(fault_en), .fault_mask(fault_mask), .fault_val(fault_val),
    .mosi_data(mosi_data), .miso_data(miso_data), .miso_valid(miso_valid)
  );

  always #5 clock = ~clock;

  task automatic model_step();
    logic [23:0] f;
    logic [47:0] dbl;
    if (reset) begin
      m_acc = 0; m_cnt = 0; m_lfsr = SD; m_prev = 0; m_mode = 0; since = 0;
      q.delete();
      for (int i = 0; i < L; i++) q.push_back(24'h0);
    end else if (enable) begin
      if (mode != m_mode) begin
        m_acc = 0; m_cnt = 0; m_lfsr = SD; m_prev = 0; m_mode = mode; since = 0;
      end
      f = 24'h0;
      case (mode)
        3'd0: f = mosi_data;
        3'd1: f = (shamt >= 5'd24) ? 24'h0 : 24'(mosi_data * (2 ** shamt));
        3'd2: begin
          dbl = {24'h0, mosi_data} * (48'd1 << (shamt % 24));
          f = dbl[23:0] | dbl[47:24];
        end
        3'd3: f = 24'hFFFFFF - mosi_data;
        3'd4: begin m_acc = 24'((25'(m_acc) + 25'(mosi_data)) % 25'h1000000); f = m_acc; end
        3'd5: begin f = m_cnt; m_cnt = m_cnt + 24'd1; end
        3'd6: begin
          f = m_lfsr;
          if (m_lfsr % 2 == 1) m_lfsr = (m_lfsr / 2) ^ PLY;
          else m_lfsr = m_lfsr / 2;
        end
        default: begin f = mosi_data ^ m_prev; m_prev = mosi_data; end
      endcase
      q.push_back(f);
      void'(q.pop_front());
      since++;
    end
  endtask

  task automatic drive(input bit en, input logic [2:0] m, input logic [4:0] sh, input logic [23:0] d);
    enable = en; mode = m; shamt = sh; mosi_data = d;
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic lit(input string name, input logic [23:0] ed, input logic ev);
    checks++;
    if (miso_data !== ed || miso_valid !== ev) begin
      errors++;
      $display("FAIL %s: got data=%h valid=%b, expected data=%h valid=%b",
               name, miso_data, miso_valid, ed, ev);
    end
  endtask

  // Per-cycle comparison against the reference model.
  always @(negedge clock) begin
    logic [23:0] ed;
    if (chk_on) begin
      ed = fault_en ? ((q[0] & ~fault_mask) | (fault_val & fault_mask)) : q[0];
      checks++;
      if (miso_data !== ed || miso_valid !== (since >= L)) begin
        errors++;
        $display("FAIL model t=%0t: got data=%h valid=%b, expected data=%h valid=%b",
                 $time, miso_data, miso_valid, ed, since >= L);
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 3'd0; shamt = 5'd0;
    fault_en = 1'b0; fault_mask = 24'h0; fault_val = 24'h0; mosi_data = 24'h0;
    drive(1'b0, 3'd0, 5'd0, 24'h0);
    drive(1'b1, 3'd0, 5'd0, 24'h0);
    reset = 1'b0;
    chk_on = 1'b1;
    lit("reset", 24'h0, 1'b0);
    // T1 pass-through latency
    drive(1'b1, 3'd0, 5'd0, 24'h000001);
    lit("t1_first", 24'h0, 1'b0);
    drive(1'b1, 3'd0, 5'd0, 24'h000002);
    lit("t1_lat", 24'h000001, 1'b1);
    drive(1'b1, 3'd0, 5'd0, 24'h0);
    lit("t1_next", 24'h000002, 1'b1);
    // T2 shift / rotate
    drive(1'b1, 3'd1, 5'd1, 24'h800001);
    lit("t2_chg", 24'h0, 1'b0);
    drive(1'b1, 3'd1, 5'd24, 24'h800001);
    lit("t2_shl1", 24'h000002, 1'b1);
    drive(1'b1, 3'd2, 5'd1, 24'h800001);
    lit("t2_shl24", 24'h000000, 1'b0);
    drive(1'b1, 3'd2, 5'd25, 24'h800001);
    lit("t2_rol1", 24'h000003, 1'b1);
    drive(1'b1, 3'd0, 5'd0, 24'h0);
    lit("t2_rol25", 24'h000003, 1'b0);
    // T3 accumulate and count
    drive(1'b1, 3'd4, 5'd0, 24'hFFFFFF);
    drive(1'b1, 3'd4, 5'd0, 24'h000002);
    lit("t3_acc1", 24'hFFFFFF, 1'b1);
    drive(1'b1, 3'd4, 5'd0, 24'h0);
    lit("t3_accwrap", 24'h000001, 1'b1);
    drive(1'b1, 3'd5, 5'd0, 24'h123456);
    drive(1'b1, 3'd5, 5'd0, 24'h654321);
    lit("t3_cnt0", 24'h0, 1'b1);
    drive(1'b1, 3'd5, 5'd0, 24'hABCDEF);
    lit("t3_cnt1", 24'h000001, 1'b1);
    // T4 CNT -> LFSR -> CNT
    drive(1'b1, 3'd6, 5'd0, 24'h0);
    lit("t4_chg", 24'h000002, 1'b0);
    drive(1'b1, 3'd6, 5'd0, 24'h0);
    lit("t4_seed", 24'h000001, 1'b1);
    drive(1'b1, 3'd6, 5'd0, 24'h0);
    lit("t4_step", 24'hE10000, 1'b1);
    drive(1'b1, 3'd5, 5'd0, 24'h0);
    drive(1'b1, 3'd5, 5'd0, 24'h0);
    lit("t4_cnt0", 24'h0, 1'b1);
    drive(1'b1, 3'd5, 5'd0, 24'h0);
    lit("t4_cnt1", 24'h000001, 1'b1);
    // T5 hold, then reset mid-stream
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 3'd4, 5'd3, 24'h777777);
      lit("t5_hold", 24'h000001, 1'b1);
    end
    drive(1'b1, 3'd4, 5'd0, 24'h000005);
    reset = 1'b1;
    drive(1'b1, 3'd4, 5'd0, 24'h000005);
    reset = 1'b0;
    lit("t5_reset", 24'h0, 1'b0);
    // T6 fault override is combinational
    drive(1'b1, 3'd0, 5'd0, 24'h000003);
    drive(1'b1, 3'd0, 5'd0, 24'h000003);
    fault_en = 1'b1; fault_mask = 24'h000001; fault_val = 24'h0;
    #1;
    lit("t6_fault", 24'h000002, 1'b1);
    fault_en = 1'b0;
    #1;
    lit("t6_nofault", 24'h000003, 1'b1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 99) < 2);
      fault_en   = ($urandom_range(0, 9) == 0);
      fault_mask = 24'($urandom);
      fault_val  = 24'($urandom);
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 9) == 0) ? 3'($urandom) : mode,
            5'($urandom), 24'($urandom));
    end
    reset = 1'b0;
    drive(1'b1, mode, 5'd0, 24'h0);
    @(posedge clock);
    #1;
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
